// File: rtl/cordic_sched.sv
// Round-robin scheduler feeding several theta requesters into one shared cordic pipeline.
// It tracks downstream FIFO credits and in-flight tags, and has a flush/drain handshake.
module cordic_sched #(
  parameter int NUM_REQ     = 4,
  parameter int OUT_CREDITS = 16,
  localparam int TAG_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_theta,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   flush,
  output logic                   cordic_valid_in,
  output logic [31:0]            cordic_theta,
  input  logic                   cordic_valid_out,
  input  logic [15:0]            cordic_cos,
  input  logic [15:0]            cordic_sin,
  output logic                   res_wr_en,
  output logic [TAG_W-1:0]       res_tag,
  output logic [15:0]            res_cos,
  output logic [15:0]            res_sin,
  input  logic                   credit_return,
  output logic                   flush_done,
  output logic                   err
);

  localparam int CW = $clog2(OUT_CREDITS + 1);
  localparam int PW = (OUT_CREDITS > 1) ? $clog2(OUT_CREDITS) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  state_t           state;
  logic [CW-1:0]    credits;
  logic [CW-1:0]    in_flight;
  logic [CW-1:0]    in_flight_nxt;
  logic [TAG_W-1:0] last_grant;
  logic [TAG_W-1:0] grant_idx;
  logic [TAG_W-1:0] cand;
  logic [TAG_W-1:0] tag_mem [OUT_CREDITS];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [31:0]      theta_arr [NUM_REQ];
  logic             grant_ok;
  logic             found;
  logic             xfer;
  logic             pop;
  int               idx;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUT_CREDITS - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) theta_arr[i] = req_theta[32*i +: 32];
  end

  assign grant_ok = !reset && (state == RUN) && (credits != '0);

  // Search starts just after the last granted requester and wraps once.
  always_comb begin
    req_ready = '0;
    grant_idx = last_grant;
    found     = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = TAG_W'(idx);
      if (grant_ok && !found && req_valid[cand]) begin
        found           = 1'b1;
        req_ready[cand] = 1'b1;
        grant_idx       = cand;
      end
    end
  end

  assign xfer = |(req_valid & req_ready);
  assign pop  = cordic_valid_out && (in_flight != '0);

  always_comb begin
    in_flight_nxt = in_flight;
    if (xfer && !pop)      in_flight_nxt = in_flight + 1'b1;
    else if (pop && !xfer) in_flight_nxt = in_flight - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (xfer) tag_mem[wr_ptr] <= grant_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= RUN;
      flush_done      <= 1'b0;
      credits         <= CW'(OUT_CREDITS);
      in_flight       <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      last_grant      <= TAG_W'(NUM_REQ - 1);
      cordic_valid_in <= 1'b0;
      cordic_theta    <= '0;
      res_wr_en       <= 1'b0;
      res_tag         <= '0;
      res_cos         <= '0;
      res_sin         <= '0;
      err             <= 1'b0;
    end else begin
      cordic_valid_in <= xfer;
      if (xfer) begin
        cordic_theta <= theta_arr[grant_idx];
        last_grant   <= grant_idx;
        wr_ptr       <= ptr_inc(wr_ptr);
      end

      res_wr_en <= pop;
      if (pop) begin
        res_tag <= tag_mem[rd_ptr];
        res_cos <= cordic_cos;
        res_sin <= cordic_sin;
        rd_ptr  <= ptr_inc(rd_ptr);
      end

      in_flight <= in_flight_nxt;

      if (xfer && !credit_return)
        credits <= credits - 1'b1;
      else if (credit_return && !xfer && credits != CW'(OUT_CREDITS))
        credits <= credits + 1'b1;

      // A result with no matching tag, or a credit beyond capacity, is a protocol error.
      if ((cordic_valid_out && in_flight == '0) ||
          (credit_return && !xfer && credits == CW'(OUT_CREDITS)))
        err <= 1'b1;

      // DRAIN looks at next-cycle in_flight so HALT lines up with the last result write.
      case (state)
        RUN: if (flush) state <= DRAIN;
        DRAIN: if (in_flight_nxt == '0) begin
          state      <= HALT;
          flush_done <= 1'b1;
        end
        HALT: if (!flush) begin
          state      <= RUN;
          flush_done <= 1'b0;
        end
        default: begin
          state      <= RUN;
          flush_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sched.sv
// Self-checking bench for cordic_sched: directed vector table, corner-case sequences,
// and a randomized run compared against a queue-based reference model.
module tb_cordic_sched;

  localparam int NR = 4;
  localparam int OC = 16;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [127:0] req_theta;
  logic [3:0]  req_ready;
  logic        flush;
  logic        cordic_valid_in;
  logic [31:0] cordic_theta;
  logic        cordic_valid_out;
  logic [15:0] cordic_cos;
  logic [15:0] cordic_sin;
  logic        res_wr_en;
  logic [1:0]  res_tag;
  logic [15:0] res_cos;
  logic [15:0] res_sin;
  logic        credit_return;
  logic        flush_done;
  logic        err;

  logic [31:0] th      [NR];
  logic [31:0] th_next [NR];

  int errors = 0;
  int checks = 0;

  localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;
  int          m_credits;
  int          m_tags[$];
  int          m_last;
  int          m_mode;
  logic        m_cvi;
  logic [31:0] m_theta;
  logic        m_wr;
  int          m_tag;
  logic [15:0] m_cos;
  logic [15:0] m_sin;
  logic        m_err;
  logic        m_done;

  typedef struct {
    logic [3:0]  rv;
    logic        cvo;
    logic [15:0] cos;
    logic [15:0] sin;
    logic [3:0]  e_ready;
    logic        e_cvi;
    logic [31:0] e_theta;
    logic        e_wr;
    logic [1:0]  e_tag;
    logic [15:0] e_cos;
    logic [15:0] e_sin;
  } vec_t;

  vec_t tbl [11];

  assign req_theta = {th[3], th[2], th[1], th[0]};

  cordic_sched #(.NUM_REQ(NR), .OUT_CREDITS(OC)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_theta(req_theta),
    .req_ready(req_ready), .flush(flush), .cordic_valid_in(cordic_valid_in),
    .cordic_theta(cordic_theta), .cordic_valid_out(cordic_valid_out),
    .cordic_cos(cordic_cos), .cordic_sin(cordic_sin), .res_wr_en(res_wr_en),
    .res_tag(res_tag), .res_cos(res_cos), .res_sin(res_sin),
    .credit_return(credit_return), .flush_done(flush_done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Grant is the first valid requester after the previous grant, when allowed to issue.
  function automatic logic [3:0] modelReady();
    logic [3:0] r;
    r = '0;
    if (reset || m_mode != M_RUN || m_credits == 0) return r;
    for (int k = 1; k <= NR; k++) begin
      int i;
      i = (m_last + k) % NR;
      if (req_valid[i]) begin
        r[i] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic modelReset();
    m_credits = OC;
    m_tags.delete();
    m_last  = NR - 1;
    m_mode  = M_RUN;
    m_cvi   = 1'b0;
    m_theta = '0;
    m_wr    = 1'b0;
    m_tag   = 0;
    m_cos   = '0;
    m_sin   = '0;
    m_err   = 1'b0;
    m_done  = 1'b0;
  endtask

  task automatic modelStep();
    logic [3:0] g;
    int         gi;
    logic       xfer;
    if (reset) begin
      modelReset();
      return;
    end
    g    = modelReady();
    xfer = (g != 4'b0000);
    gi   = 0;
    for (int i = 0; i < NR; i++) if (g[i]) gi = i;
    m_cvi = xfer;
    if (xfer) m_theta = th[gi];
    m_wr = 1'b0;
    if (cordic_valid_out) begin
      if (m_tags.size() == 0) m_err = 1'b1;
      else begin
        m_wr  = 1'b1;
        m_tag = m_tags.pop_front();
        m_cos = cordic_cos;
        m_sin = cordic_sin;
      end
    end
    if (xfer) begin
      m_tags.push_back(gi);
      m_last = gi;
    end
    if (xfer && !credit_return) m_credits--;
    else if (credit_return && !xfer) begin
      if (m_credits == OC) m_err = 1'b1;
      else m_credits++;
    end
    case (m_mode)
      M_RUN:   if (flush) m_mode = M_DRAIN;
      M_DRAIN: if (m_tags.size() == 0) m_mode = M_HALT;
      default: if (!flush) m_mode = M_RUN;
    endcase
    m_done = (m_mode == M_HALT);
  endtask

  task automatic compareModel();
    checkOutput("m_req_ready", 32'(req_ready), 32'(modelReady()));
    checkOutput("m_cordic_valid_in", 32'(cordic_valid_in), 32'(m_cvi));
    checkOutput("m_cordic_theta", cordic_theta, m_theta);
    checkOutput("m_res_wr_en", 32'(res_wr_en), 32'(m_wr));
    checkOutput("m_res_tag", 32'(res_tag), 32'(m_tag));
    checkOutput("m_res_cos", 32'(res_cos), 32'(m_cos));
    checkOutput("m_res_sin", 32'(res_sin), 32'(m_sin));
    checkOutput("m_flush_done", 32'(flush_done), 32'(m_done));
    checkOutput("m_err", 32'(err), 32'(m_err));
  endtask

  // Drives one cycle of inputs, compares mid-cycle, then advances the model past the edge.
  task automatic applyStimulus(input logic rst, input logic [3:0] rv, input logic fl,
                               input logic cvo, input logic [15:0] cs, input logic [15:0] sn,
                               input logic cr);
    @(posedge clk);
    #1;
    reset            = rst;
    req_valid        = rv;
    flush            = fl;
    cordic_valid_out = cvo;
    cordic_cos       = cs;
    cordic_sin       = sn;
    credit_return    = cr;
    for (int i = 0; i < NR; i++) th[i] = th_next[i];
    @(negedge clk);
    compareModel();
    modelStep();
  endtask

  initial begin
    int   grants;
    logic fl_r;
    logic [3:0] e_rr;

    reset = 1'b1; req_valid = '0; flush = 1'b0; cordic_valid_out = 1'b0;
    cordic_cos = '0; cordic_sin = '0; credit_return = 1'b0;
    th_next[0] = 32'h3243F6A8; th_next[1] = 32'h11111111;
    th_next[2] = 32'h22222222; th_next[3] = 32'h33333333;
    for (int i = 0; i < NR; i++) th[i] = th_next[i];
    modelReset();

    tbl[0]  = '{4'b0001, 1'b0, 16'h0000, 16'h0000, 4'b0001, 1'b0, 32'h00000000, 1'b0, 2'd0, 16'h0000, 16'h0000};
    tbl[1]  = '{4'b0000, 1'b0, 16'h0000, 16'h0000, 4'b0000, 1'b1, 32'h3243F6A8, 1'b0, 2'd0, 16'h0000, 16'h0000};
    tbl[2]  = '{4'b0101, 1'b0, 16'h0000, 16'h0000, 4'b0100, 1'b0, 32'h3243F6A8, 1'b0, 2'd0, 16'h0000, 16'h0000};
    tbl[3]  = '{4'b0101, 1'b0, 16'h0000, 16'h0000, 4'b0001, 1'b1, 32'h22222222, 1'b0, 2'd0, 16'h0000, 16'h0000};
    tbl[4]  = '{4'b1000, 1'b0, 16'h0000, 16'h0000, 4'b1000, 1'b1, 32'h3243F6A8, 1'b0, 2'd0, 16'h0000, 16'h0000};
    tbl[5]  = '{4'b0000, 1'b1, 16'h0F00, 16'h0001, 4'b0000, 1'b1, 32'h33333333, 1'b0, 2'd0, 16'h0000, 16'h0000};
    tbl[6]  = '{4'b0000, 1'b1, 16'h1000, 16'h0002, 4'b0000, 1'b0, 32'h33333333, 1'b1, 2'd0, 16'h0F00, 16'h0001};
    tbl[7]  = '{4'b0000, 1'b1, 16'h2000, 16'h0003, 4'b0000, 1'b0, 32'h33333333, 1'b1, 2'd2, 16'h1000, 16'h0002};
    tbl[8]  = '{4'b0000, 1'b1, 16'h3000, 16'h0004, 4'b0000, 1'b0, 32'h33333333, 1'b1, 2'd0, 16'h2000, 16'h0003};
    tbl[9]  = '{4'b0000, 1'b0, 16'h0000, 16'h0000, 4'b0000, 1'b0, 32'h33333333, 1'b1, 2'd3, 16'h3000, 16'h0004};
    tbl[10] = '{4'b0000, 1'b0, 16'h0000, 16'h0000, 4'b0000, 1'b0, 32'h33333333, 1'b0, 2'd3, 16'h3000, 16'h0004};

    $display("[TB] reset and directed vector table");
    applyStimulus(1'b1, 4'hF, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    checkOutput("ready_in_reset", 32'(req_ready), 32'h0);
    for (int k = 0; k < 11; k++) begin
      applyStimulus(1'b0, tbl[k].rv, 1'b0, tbl[k].cvo, tbl[k].cos, tbl[k].sin, 1'b0);
      checkOutput($sformatf("tbl%0d_ready", k), 32'(req_ready), 32'(tbl[k].e_ready));
      checkOutput($sformatf("tbl%0d_cvi", k), 32'(cordic_valid_in), 32'(tbl[k].e_cvi));
      checkOutput($sformatf("tbl%0d_theta", k), cordic_theta, tbl[k].e_theta);
      checkOutput($sformatf("tbl%0d_wr", k), 32'(res_wr_en), 32'(tbl[k].e_wr));
      checkOutput($sformatf("tbl%0d_tag", k), 32'(res_tag), 32'(tbl[k].e_tag));
      checkOutput($sformatf("tbl%0d_cos", k), 32'(res_cos), 32'(tbl[k].e_cos));
      checkOutput($sformatf("tbl%0d_sin", k), 32'(res_sin), 32'(tbl[k].e_sin));
    end

    $display("[TB] round-robin order and credit exhaustion");
    applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    grants = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b0, 4'hF, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      e_rr = 4'b0001 << (k % 4);
      if (k < 8) checkOutput($sformatf("rr_order%0d", k), 32'(req_ready), 32'(e_rr));
      grants += $countones(req_ready);
    end
    checkOutput("credit_limit_grants", 32'(grants), 32'd16);
    applyStimulus(1'b0, 4'hF, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    checkOutput("ready_at_zero_credits", 32'(req_ready), 32'h0);
    grants = 0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 4'hF, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      grants += $countones(req_ready);
    end
    checkOutput("grants_after_one_credit", 32'(grants), 32'd1);

    $display("[TB] flush and drain");
    applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 4'b0111, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    applyStimulus(1'b0, 4'hF, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    checkOutput("drain_no_grant", 32'(req_ready), 32'h0);
    applyStimulus(1'b0, 4'hF, 1'b1, 1'b1, 16'h0101, 16'h0, 1'b0);
    applyStimulus(1'b0, 4'hF, 1'b1, 1'b1, 16'h0202, 16'h0, 1'b0);
    applyStimulus(1'b0, 4'hF, 1'b0, 1'b1, 16'h0303, 16'h0, 1'b0);
    checkOutput("drain_early_release_ready", 32'(req_ready), 32'h0);
    checkOutput("drain_not_done_yet", 32'(flush_done), 32'h0);
    applyStimulus(1'b0, 4'hF, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    checkOutput("flush_done_after_last", 32'(flush_done), 32'h1);
    checkOutput("last_result_written", 32'(res_wr_en), 32'h1);
    checkOutput("halt_no_grant", 32'(req_ready), 32'h0);
    applyStimulus(1'b0, 4'hF, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    checkOutput("resume_grant", 32'(req_ready), 32'b1000);
    checkOutput("resume_done_low", 32'(flush_done), 32'h0);

    $display("[TB] protocol errors");
    applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    checkOutput("err_credit_overflow", 32'(err), 32'h1);
    applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 16'h7777, 16'h0, 1'b0);
    checkOutput("err_cleared_by_reset", 32'(err), 32'h0);
    applyStimulus(1'b0, 4'b0010, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    checkOutput("err_spurious_result", 32'(err), 32'h1);
    checkOutput("spurious_no_write", 32'(res_wr_en), 32'h0);
    checkOutput("grant_after_err", 32'(req_ready), 32'b0010);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 16'h5555, 16'h6666, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    checkOutput("post_err_write", 32'(res_wr_en), 32'h1);
    checkOutput("post_err_tag", 32'(res_tag), 32'd1);
    checkOutput("post_err_cos", 32'(res_cos), 32'h5555);
    checkOutput("err_sticky", 32'(err), 32'h1);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    applyStimulus(1'b0, 4'b0010, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 16'h1234, 16'h0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    checkOutput("stale_result_no_write", 32'(res_wr_en), 32'h0);
    checkOutput("stale_result_err", 32'(err), 32'h1);

    $display("[TB] randomized run");
    applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    fl_r = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      logic       cvo, cr, rst;
      logic [3:0] rv;
      for (int i = 0; i < NR; i++) th_next[i] = $urandom;
      rv = 4'($urandom);
      if ($urandom_range(0, 99) < 3) fl_r = !fl_r;
      cvo = (m_tags.size() > 0 && $urandom_range(0, 1) == 1) || ($urandom_range(0, 199) == 0);
      cr  = ((m_credits + m_tags.size()) < OC) && ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 299) == 0);
      applyStimulus(rst, rv, fl_r, cvo, 16'($urandom), 16'($urandom), cr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cordic_sched.md
CORDIC_SCHED -- requirements
Module: cordic_sched

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters sharing one cordic pipeline.
REQ-002 The block SHALL have parameter OUT_CREDITS, default 16, meaning the maximum results outstanding toward the downstream cos/sin FIFOs (range 1..255).
REQ-003 The block SHALL have the following ports, one per line (name  direction  width  meaning):
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  requester i has a theta.
- req_theta  in  32*NUM_REQ  theta of requester i, bits [32i+31:32i].
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
- flush  in  1  level request to stop issuing and drain.
- cordic_valid_in  out  1  issue strobe to cordic.
- cordic_theta  out  32  theta to cordic.
- cordic_valid_out  in  1  cordic result strobe.
- cordic_cos  in  16  cordic cos result.
- cordic_sin  in  16  cordic sin result.
- res_wr_en  out  1  write strobe to downstream cos/sin/tag FIFOs.
- res_tag  out  $clog2(NUM_REQ)  requester index of the result.
- res_cos  out  16  registered cos.
- res_sin  out  16  registered sin.
- credit_return  in  1  downstream popped one result.
- flush_done  out  1  high in HALT state.
- err  out  1  sticky protocol-error flag.

Function
REQ-004 The block SHALL have FSM states RUN, DRAIN and HALT.
REQ-005 RUN SHALL transition to DRAIN when flush=1.
REQ-006 DRAIN SHALL transition to HALT when in_flight==0.
REQ-007 HALT SHALL transition to RUN when flush=0.
REQ-008 DRAIN/HALT with flush deasserted before in_flight==0 SHALL still complete the drain to HALT before returning to RUN.
REQ-009 Grants SHALL occur only in RUN with credits>0 and at least one req_valid set.
REQ-010 At most one req_ready bit SHALL be set per cycle.
REQ-011 req_ready SHALL be combinational from req_valid, the round-robin pointer, credits and state.
REQ-012 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQ.
REQ-013 last_grant SHALL update only on a transfer.
REQ-014 A transfer SHALL drive cordic_valid_in=1 and cordic_theta=granted theta on the next cycle (latency 1).
REQ-015 cordic_valid_in SHALL be 0 otherwise, with cordic_theta holding its last value.
REQ-016 Each transfer SHALL push its requester index into an in-order tag FIFO of depth OUT_CREDITS.
REQ-017 Each cordic_valid_out SHALL pop the tag FIFO.
REQ-018 One cycle after cordic_valid_out, res_wr_en SHALL be 1 with res_cos/res_sin = cordic outputs and res_tag = popped tag.
REQ-019 A tag-FIFO push and pop in the same cycle SHALL both take effect.
REQ-020 credits SHALL be a counter 0..OUT_CREDITS: -1 on transfer, +1 on credit_return, unchanged on both together.
REQ-021 credit_return with credits==OUT_CREDITS and no transfer SHALL leave credits unchanged and set err.
REQ-022 in_flight SHALL be a counter: +1 on transfer, -1 on cordic_valid_out, unchanged on both together.
REQ-023 cordic_valid_out with in_flight==0 SHALL produce no res_wr_en, SHALL leave counters unchanged, and SHALL set err.
REQ-024 err SHALL clear only on reset.
REQ-025 The block SHALL guarantee in_flight <= OUT_CREDITS - credits (by construction).

Reset
REQ-026 reset=1 at a clock edge SHALL force: state=RUN, credits=OUT_CREDITS, in_flight=0, tag FIFO empty, last_grant=NUM_REQ-1, cordic_valid_in=0, cordic_theta=0, res_wr_en=0, res_tag=0, res_cos=0, res_sin=0, err=0.
REQ-027 req_ready SHALL be 0 while reset=1.
REQ-028 Reset mid-operation SHALL discard in-flight tags; cordic results arriving after reset SHALL be handled per REQ-023 (no write, err set).

Verification
REQ-029 Single request: req_valid=0001, theta=0x3243F6A8 -> req_ready=0001 same cycle; cordic_valid_in=1, cordic_theta=0x3243F6A8 next cycle; credits=15.
REQ-030 All four requesting continuously from reset -> grants in order 0,1,2,3,0,... with one grant per cycle.
REQ-031 No credit_return, continuous requests -> exactly 16 transfers, then req_ready=0000; one credit_return -> exactly one further grant.
REQ-032 Issue tags 2,0,3, then three cordic_valid_out strobes with cos=0x1000,0x2000,0x3000 -> three res_wr_en pulses, tags 2,0,3, matching cos, each 1 cycle after its strobe.
REQ-033 flush=1 with 3 in flight -> no new grants; flush_done rises the cycle after the 3rd cordic_valid_out; flush=0 -> RUN and grants resume.
REQ-034 cordic_valid_out with nothing in flight, and credit_return at credits=16 -> err=1, no res_wr_en, counters unchanged; reset -> err=0.
